// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory-port arbiter.
// Holds the FSM state codes, the owner codes and the BUSY counter width.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Generic n-bit 2:1 multiplexer: y = sel ? b : a.
module mem_port_arbiter_mux #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign y[gi] = sel ? b[gi] : a[gi];
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for one shared single-port memory.
// Round-robin on conflicts; each access holds the memory for LATENCY cycles, then grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int n       = 32,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [n-1:0] if_addr,
    output logic         if_gnt,
    output logic [n-1:0] if_rdata,
    input  logic         mem_req,
    input  logic         mem_we,
    input  logic [n-1:0] mem_addr,
    input  logic [n-1:0] mem_wdata,
    output logic         mem_gnt,
    output logic [n-1:0] mem_rdata,
    output logic         ram_sel,
    output logic [n-1:0] ram_addr,
    output logic         ram_we,
    output logic [n-1:0] ram_wdata,
    input  logic [n-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    logic [1:0]       state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             last_owner_reg, last_owner_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [n-1:0]     if_rdata_reg, if_rdata_next;
    logic [n-1:0]     mem_rdata_reg, mem_rdata_next;

    logic final_busy;
    logic rd_load;

    assign final_busy = (state_reg == ST_BUSY) && (cnt_reg == '0);
    // A data-port write never disturbs either captured read value.
    assign rd_load    = final_busy && !((owner_reg == OWNER_MEM) && mem_we);

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        cnt_next        = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    state_next = ST_BUSY;
                    cnt_next   = LAT_M1;
                    if (if_req && mem_req)
                        owner_next = ~last_owner_reg;
                    else
                        owner_next = mem_req ? OWNER_MEM : OWNER_IF;
                end
            end
            ST_BUSY: begin
                if (cnt_reg == '0)
                    state_next = ST_RESP;
                else
                    cnt_next = cnt_reg - 1'b1;
            end
            ST_RESP: begin
                last_owner_next = owner_reg;
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        if_rdata_next  = if_rdata_reg;
        mem_rdata_next = mem_rdata_reg;
        if (rd_load && (owner_reg == OWNER_IF))
            if_rdata_next = ram_rdata;
        if (rd_load && (owner_reg == OWNER_MEM))
            mem_rdata_next = ram_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWNER_IF;
            last_owner_reg <= OWNER_MEM;
            cnt_reg        <= '0;
            if_rdata_reg   <= '0;
            mem_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            cnt_reg        <= cnt_next;
            if_rdata_reg   <= if_rdata_next;
            mem_rdata_reg  <= mem_rdata_next;
        end
    end

    // Grants and write enable decode straight from state so reset clears them at once.
    assign if_gnt    = (state_reg == ST_RESP) && (owner_reg == OWNER_IF);
    assign mem_gnt   = (state_reg == ST_RESP) && (owner_reg == OWNER_MEM);
    assign ram_we    = (state_reg == ST_BUSY) && (owner_reg == OWNER_MEM) && mem_we;
    assign ram_sel   = owner_reg;
    assign ram_wdata = mem_wdata;
    assign if_rdata  = if_rdata_reg;
    assign mem_rdata = mem_rdata_reg;

    mem_port_arbiter_mux #(
        .W(n)
    ) u_addr_mux (
        .a  (if_addr),
        .b  (mem_addr),
        .sel(ram_sel),
        .y  (ram_addr)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_mem_port_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         if_req = 1'b0;
    logic [N-1:0] if_addr = '0;
    logic         mem_req = 1'b0;
    logic         mem_we = 1'b0;
    logic [N-1:0] mem_addr = '0;
    logic [N-1:0] mem_wdata = '0;
    logic [N-1:0] ram_rdata = '0;

    logic         a_if_gnt, a_mem_gnt, a_ram_sel, a_ram_we;
    logic [N-1:0] a_if_rdata, a_mem_rdata, a_ram_addr, a_ram_wdata;
    logic         b_if_gnt, b_mem_gnt, b_ram_sel, b_ram_we;
    logic [N-1:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.n(N), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rdata(a_if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(a_mem_gnt), .mem_rdata(a_mem_rdata),
        .ram_sel(a_ram_sel), .ram_addr(a_ram_addr), .ram_we(a_ram_we),
        .ram_wdata(a_ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.n(N), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rdata(b_if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(b_mem_gnt), .mem_rdata(b_mem_rdata),
        .ram_sel(b_ram_sel), .ram_addr(b_ram_addr), .ram_we(b_ram_we),
        .ram_wdata(b_ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grants of either instance must never coincide.
    always @(negedge clk) begin
        checks++;
        assert (!(a_if_gnt && a_mem_gnt) && !(b_if_gnt && b_mem_gnt)) else begin
            failures++;
            $error("FAIL gnt_mutex observed=%b%b_%b%b expected=no_pair",
                   a_if_gnt, a_mem_gnt, b_if_gnt, b_mem_gnt);
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_if_gnt", N'(a_if_gnt), 0);
        chk("rst_mem_gnt", N'(a_mem_gnt), 0);
        chk("rst_ram_sel", N'(a_ram_sel), 0);
        chk("rst_ram_we", N'(a_ram_we), 0);
        chk("rst_if_rdata", a_if_rdata, 0);
        chk("rst_mem_rdata", a_mem_rdata, 0);
        tick();
        #3 rst = 1'b1;
        tick();
        $display("txn reset: done");

        // Single fetch
        if_req = 1'b1; if_addr = 32'h10; ram_rdata = 32'hDEADBEEF;
        chk("f_c0_sel", N'(a_ram_sel), 0);
        tick();
        chk("f_c1_gnt", N'(a_if_gnt), 0);
        chk("f_c1_sel", N'(a_ram_sel), 0);
        chk("f_c1_addr", a_ram_addr, 32'h10);
        tick();
        chk("f_c2_gnt", N'(a_if_gnt), 0);
        chk("f_c2_sel", N'(a_ram_sel), 0);
        tick();
        chk("f_c3_gnt", N'(a_if_gnt), 1);
        chk("f_c3_mgnt", N'(a_mem_gnt), 0);
        chk("f_c3_rdata", a_if_rdata, 32'hDEADBEEF);
        chk("f_c3_sel", N'(a_ram_sel), 0);
        if_req = 1'b0;
        tick();
        chk("f_c4_gnt", N'(a_if_gnt), 0);
        $display("txn fetch addr=10 rdata=%h", a_if_rdata);

        // Single write
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h12345678;
        ram_rdata = 32'hCAFEF00D;
        chk("w_c0_we", N'(a_ram_we), 0);
        tick();
        chk("w_c1_we", N'(a_ram_we), 1);
        chk("w_c1_sel", N'(a_ram_sel), 1);
        chk("w_c1_addr", a_ram_addr, 32'h40);
        chk("w_c1_wdata", a_ram_wdata, 32'h12345678);
        tick();
        chk("w_c2_we", N'(a_ram_we), 1);
        chk("w_c2_gnt", N'(a_mem_gnt), 0);
        tick();
        chk("w_c3_gnt", N'(a_mem_gnt), 1);
        chk("w_c3_we", N'(a_ram_we), 0);
        chk("w_c3_mrdata", a_mem_rdata, 0);
        chk("w_c3_ifrdata", a_if_rdata, 32'hDEADBEEF);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        $display("txn write addr=40 wdata=12345678");

        // Conflict: IF first, then MEM, then IF, then MEM
        if_req = 1'b1; mem_req = 1'b1; if_addr = 32'h20; mem_addr = 32'h80;
        ram_rdata = 32'h11111111;
        tick();
        chk("c_c1_sel", N'(a_ram_sel), 0);
        chk("c_c1_addr", a_ram_addr, 32'h20);
        tick();
        tick();
        chk("c_c3_ifgnt", N'(a_if_gnt), 1);
        chk("c_c3_mgnt", N'(a_mem_gnt), 0);
        chk("c_c3_rdata", a_if_rdata, 32'h11111111);
        if_req = 1'b0; ram_rdata = 32'h22222222;
        tick();
        tick();
        chk("c_c5_sel", N'(a_ram_sel), 1);
        chk("c_c5_addr", a_ram_addr, 32'h80);
        tick();
        chk("c_c6_mgnt", N'(a_mem_gnt), 0);
        tick();
        chk("c_c7_mgnt", N'(a_mem_gnt), 1);
        chk("c_c7_ifgnt", N'(a_if_gnt), 0);
        chk("c_c7_mrdata", a_mem_rdata, 32'h22222222);
        if_req = 1'b1;
        tick();
        tick();
        chk("c_c9_sel", N'(a_ram_sel), 0);
        tick();
        tick();
        chk("c_c11_ifgnt", N'(a_if_gnt), 1);
        tick();
        tick();
        chk("c_c13_sel", N'(a_ram_sel), 1);
        tick();
        tick();
        chk("c_c15_mgnt", N'(a_mem_gnt), 1);
        chk("c_c15_ifgnt", N'(a_if_gnt), 0);
        if_req = 1'b0; mem_req = 1'b0;
        tick();
        $display("txn conflict: IF c3, MEM c7, IF c11, MEM c15");

        // Abort tolerance
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h44; ram_rdata = 32'h33333333;
        tick();
        mem_req = 1'b0;
        tick();
        chk("a_c2_mgnt", N'(a_mem_gnt), 0);
        tick();
        chk("a_c3_mgnt", N'(a_mem_gnt), 1);
        chk("a_c3_mrdata", a_mem_rdata, 32'h33333333);
        tick();
        $display("txn abort-tolerant read addr=44 rdata=%h", a_mem_rdata);

        // Reset in the middle of a read
        if_req = 1'b1; if_addr = 32'h50; ram_rdata = 32'h44444444;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("r_if_gnt", N'(a_if_gnt), 0);
        chk("r_mem_gnt", N'(a_mem_gnt), 0);
        chk("r_ram_sel", N'(a_ram_sel), 0);
        chk("r_ram_we", N'(a_ram_we), 0);
        chk("r_if_rdata", a_if_rdata, 0);
        chk("r_mem_rdata", a_mem_rdata, 0);
        tick();
        chk("r_held_gnt", N'(a_if_gnt), 0);
        #3 rst = 1'b1;
        tick();
        chk("r_c1_gnt", N'(a_if_gnt), 0);
        tick();
        chk("r_c2_gnt", N'(a_if_gnt), 0);
        tick();
        chk("r_c3_gnt", N'(a_if_gnt), 1);
        chk("r_c3_rdata", a_if_rdata, 32'h44444444);
        if_req = 1'b0;
        tick();
        $display("txn reset mid-read, regrant rdata=%h", a_if_rdata);

        // LATENCY=1 instance
        rst = 1'b0;
        tick();
        #3 rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h60; ram_rdata = 32'h55555555;
        tick();
        chk("l1_c1_gnt", N'(b_if_gnt), 0);
        chk("l1_c1_sel", N'(b_ram_sel), 0);
        tick();
        chk("l1_c2_gnt", N'(b_if_gnt), 1);
        chk("l1_c2_rdata", b_if_rdata, 32'h55555555);
        if_req = 1'b0;
        tick();
        chk("l1_c3_gnt", N'(b_if_gnt), 0);
        $display("txn latency1 fetch rdata=%h", b_if_rdata);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
